// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, oversampling
// constants and the layout of the CPU-visible status/data word.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } rx_state_t;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 7;

   localparam int DATA_LSB  = 0;
   localparam int VALID_BIT = 16;
   localparam int OVR_BIT   = 17;
   localparam int FERR_BIT  = 18;

   function automatic logic [31:0] make_word(input logic ferr, input logic ovr,
                                             input logic valid, input logic [7:0] data);
      logic [31:0] w;
      w = '0;
      w[DATA_LSB +: 8] = data;
      w[VALID_BIT]     = valid;
      w[OVR_BIT]       = ovr;
      w[FERR_BIT]      = ferr;
      return w;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate occupancy counter.
module uart_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A pop frees the head slot in the same edge, so a full FIFO may still accept.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_controller.sv
// 8N1 UART receiver with 16x oversampling, an RX FIFO and a registered
// status/data word carrying valid, overrun and framing-error flags.
module uart_rx_controller
   import uart_pkg::*;
#(
   parameter int DIVISOR    = 27,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        serial_in,
   input  logic        readenable,
   output logic [31:0] readdata,
   output logic        rx_avail,
   output logic        rx_error
);

   localparam int DW = $clog2(DIVISOR);

   logic            sync1;
   logic            rx_s;
   logic [DW-1:0]   div_cnt;
   logic            tick;
   rx_state_t       state;
   logic [3:0]      s;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;
   logic            ovr_flag;
   logic            ferr_flag;
   logic            stop_sample;
   logic            push;
   logic            pop;
   logic            ferr_evt;
   logic            ovr_evt;
   logic [7:0]      head;
   logic            empty;
   logic            full;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= serial_in;
         rx_s  <= sync1;
      end
   end

   assign tick = (div_cnt == DW'(DIVISOR - 1));

   always_ff @(posedge clk) begin
      if (reset || tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 1'b1;
   end

   // Stop-bit decisions are decoded from the FSM so the byte lands in the
   // FIFO on the same edge that ends the stop sample.
   assign stop_sample = (state == ST_STOP) && tick && (s == 4'(OVERSAMPLE - 1));
   assign push        = stop_sample && rx_s;
   assign ferr_evt    = stop_sample && !rx_s;
   assign pop         = readenable && !empty;
   assign ovr_evt     = push && full && !pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         s       <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!rx_s) begin
                  state <= ST_START;
                  s     <= '0;
               end
            end
            ST_START: begin
               if (tick) begin
                  if (s == 4'(MID_SAMPLE)) begin
                     s       <= '0;
                     bit_idx <= '0;
                     state   <= rx_s ? ST_IDLE : ST_DATA;
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  s <= s + 1'b1;
                  if (s == 4'(OVERSAMPLE - 1)) begin
                     shreg[bit_idx] <= rx_s;
                     bit_idx        <= bit_idx + 1'b1;
                     if (bit_idx == 3'd7)
                        state <= ST_STOP;
                  end
               end
            end
            ST_STOP: begin
               if (tick) begin
                  s <= s + 1'b1;
                  if (s == 4'(OVERSAMPLE - 1))
                     state <= rx_s ? ST_IDLE : ST_BREAK;
               end
            end
            ST_BREAK: begin
               if (rx_s)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (shreg),
      .pop       (pop),
      .head      (head),
      .empty     (empty),
      .full      (full)
   );

   // A read reports and clears the flags; an event on the same edge survives.
   always_ff @(posedge clk) begin
      if (reset) begin
         readdata  <= '0;
         ovr_flag  <= 1'b0;
         ferr_flag <= 1'b0;
      end else if (readenable) begin
         readdata  <= make_word(ferr_flag, ovr_flag, !empty, empty ? 8'd0 : head);
         ovr_flag  <= ovr_evt;
         ferr_flag <= ferr_evt;
      end else begin
         ovr_flag  <= ovr_flag | ovr_evt;
         ferr_flag <= ferr_flag | ferr_evt;
      end
   end

   assign rx_avail = !empty;
   assign rx_error = ovr_flag | ferr_flag;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Bench for uart_rx_controller: serial frame driver, byte-level FIFO/flag
// model, and a scoreboard that checks every registered read word.
module tb_uart_rx_controller;

   localparam int DIVISOR    = 4;
   localparam int FIFO_DEPTH = 8;
   localparam int BIT_CYC    = DIVISOR * 16;

   logic        clk;
   logic        reset;
   logic        serial_in;
   logic        readenable;
   logic [31:0] readdata;
   logic        rx_avail;
   logic        rx_error;

   uart_rx_controller #(
      .DIVISOR    (DIVISOR),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .serial_in  (serial_in),
      .readenable (readenable),
      .readdata   (readdata),
      .rx_avail   (rx_avail),
      .rx_error   (rx_error)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   logic [31:0] exp_q[$];
   logic [7:0]  model_q[$];
   logic        m_ovr = 1'b0;
   logic        m_ferr = 1'b0;
   logic        rd_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp)
         passed++;
      else
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // monitor: readdata is compared the cycle after each read strobe
   always @(posedge clk) rd_seen <= readenable && !reset;

   always @(negedge clk) begin
      if (rd_seen) begin
         if (exp_q.size() == 0) begin
            check("readdata_unexpected", readdata, 32'hxxxx_xxxx);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("readdata", readdata, e);
         end
      end
   end

   // reference model: a received byte joins the queue unless it is full
   task automatic model_rx(input logic [7:0] d);
      if (model_q.size() == FIFO_DEPTH)
         m_ovr = 1'b1;
      else
         model_q.push_back(d);
   endtask

   task automatic do_read();
      logic [31:0] w;
      w = 32'd0;
      if (model_q.size() != 0) begin
         w[16]  = 1'b1;
         w[7:0] = model_q.pop_front();
      end
      w[17] = m_ovr;
      w[18] = m_ferr;
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
      exp_q.push_back(w);
      @(posedge clk) #1 readenable = 1'b1;
      @(posedge clk) #1 readenable = 1'b0;
   endtask

   // driver tasks
   task automatic drive_bit(input logic v);
      serial_in = v;
      repeat (BIT_CYC) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      @(posedge clk) #1;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop_bit);
      if (stop_bit) model_rx(d);
      else          m_ferr = 1'b1;
   endtask

   task automatic idle_cycles(input int n);
      serial_in = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [7:0] seq_bytes [3];
   logic [7:0] ovf_bytes [FIFO_DEPTH+1];

   initial begin
      serial_in  = 1'b1;
      readenable = 1'b0;
      reset      = 1'b1;
      repeat (4) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_readdata", readdata, 32'd0);
      check("reset_rx_avail", {31'd0, rx_avail}, 32'd0);
      check("reset_rx_error", {31'd0, rx_error}, 32'd0);
      idle_cycles(20);

      // single byte with arrival window
      fork
         send_frame(8'hA5, 1'b1);
         begin
            @(posedge clk);
            repeat (600) @(posedge clk);
            @(negedge clk);
            check("avail_before_stop", {31'd0, rx_avail}, 32'd0);
            repeat (20) @(posedge clk);
            @(negedge clk);
            check("avail_after_stop", {31'd0, rx_avail}, 32'd1);
         end
      join
      idle_cycles(10);
      do_read();
      @(negedge clk);
      check("avail_after_read", {31'd0, rx_avail}, 32'd0);

      // back-to-back frames then an empty read
      seq_bytes[0] = 8'h00; seq_bytes[1] = 8'hFF; seq_bytes[2] = 8'h3C;
      for (int i = 0; i < 3; i++) send_frame(seq_bytes[i], 1'b1);
      idle_cycles(10);
      for (int i = 0; i < 4; i++) do_read();

      // overrun
      for (int i = 0; i <= FIFO_DEPTH; i++) begin
         ovf_bytes[i] = 8'($urandom_range(0, 255));
         send_frame(ovf_bytes[i], 1'b1);
      end
      idle_cycles(10);
      @(negedge clk);
      check("ovr_rx_error", {31'd0, rx_error}, 32'd1);
      do_read();
      @(negedge clk);
      check("ovr_cleared", {31'd0, rx_error}, 32'd0);
      for (int i = 1; i < FIFO_DEPTH; i++) do_read();
      do_read();

      // framing error, held break, then a normal byte
      send_frame(8'h55, 1'b0);
      repeat (20 * BIT_CYC) @(posedge clk);
      #1 idle_cycles(BIT_CYC);
      @(negedge clk);
      check("ferr_rx_error", {31'd0, rx_error}, 32'd1);
      check("ferr_no_push", {31'd0, rx_avail}, 32'd0);
      send_frame(8'h12, 1'b1);
      idle_cycles(10);
      do_read();
      do_read();

      // short glitch on idle line
      @(posedge clk) #1 serial_in = 1'b0;
      repeat (3 * DIVISOR) @(posedge clk);
      #1 idle_cycles(2 * BIT_CYC);
      @(negedge clk);
      check("glitch_no_push", {31'd0, rx_avail}, 32'd0);
      check("glitch_no_flag", {31'd0, rx_error}, 32'd0);
      send_frame(8'h81, 1'b1);
      idle_cycles(10);
      do_read();

      // reset in the middle of a data bit
      send_frame(8'h21, 1'b1);
      send_frame(8'h43, 1'b1);
      @(posedge clk) #1;
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      serial_in = 1'b0;
      repeat (BIT_CYC / 2) @(posedge clk);
      #1 reset = 1'b1;
      serial_in = 1'b1;
      @(posedge clk) #1 reset = 1'b0;
      model_q.delete();
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
      @(negedge clk);
      check("midreset_rx_avail", {31'd0, rx_avail}, 32'd0);
      check("midreset_readdata", readdata, 32'd0);
      check("midreset_rx_error", {31'd0, rx_error}, 32'd0);
      idle_cycles(2 * BIT_CYC);
      do_read();
      send_frame(8'h7E, 1'b1);
      idle_cycles(10);
      do_read();

      // randomized traffic with interleaved reads
      for (int i = 0; i < 14; i++) begin
         send_frame(8'($urandom_range(0, 255)), 1'b1);
         idle_cycles($urandom_range(0, 80));
         if ($urandom_range(0, 2) == 0) begin
            int n;
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) do_read();
         end
      end
      idle_cycles(10);
      for (int i = 0; i <= FIFO_DEPTH; i++) do_read();

      repeat (5) @(posedge clk);
      @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
